// File: rtl/adc_serial_reader.sv
// Serial ADC readout: on trigger, clocks Width bits out of the ADC (MSB first)
// and presents the sample as one AXI4-Stream beat with packet framing.
module adc_serial_reader #(
    parameter int Width  = 24,
    parameter int ClkDiv = 2
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        trigger,
    output logic        sck,
    input  logic        sdo,
    input  logic [15:0] packet_len,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic        ready,
    output logic        last,
    output logic        overrun
);

    typedef enum logic [1:0] {IDLE, SHIFT, OUTPUT} state_e;

    state_e           state_q, state_d;
    logic [7:0]       div_q, div_d;
    logic [5:0]       bit_q, bit_d;
    logic             sck_q, sck_d;
    logic [Width-1:0] shift_q, shift_d;
    logic [Width:0]   shift_ext;
    logic [15:0]      beat_q, beat_d;
    logic             last_q, last_d;
    logic             overrun_q, overrun_d;
    logic             armed_q, armed_d;
    logic             div_tc;
    logic             tlast_c;

    assign shift_ext = {shift_q, sdo};
    assign div_tc    = (div_q == 8'(ClkDiv - 1));
    // ">=" so a packet_len shrunk below the current count still closes the packet
    assign tlast_c   = (packet_len == 16'd0) || (beat_q >= packet_len - 16'd1);

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sck_d     = sck_q;
        shift_d   = shift_q;
        beat_d    = beat_q;
        last_d    = 1'b0;
        overrun_d = overrun_q;
        armed_d   = 1'b1;

        if (trigger && state_q != IDLE) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                div_d = 8'd0;
                bit_d = 6'd0;
                sck_d = 1'b0;
                if (trigger && armed_q) state_d = SHIFT;
            end
            SHIFT: begin
                if (div_tc) begin
                    div_d = 8'd0;
                    sck_d = ~sck_q;
                    if (!sck_q) begin
                        shift_d = shift_ext[Width-1:0];
                    end else begin
                        bit_d = bit_q + 6'd1;
                        if (bit_q == 6'(Width - 1)) state_d = OUTPUT;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            OUTPUT: begin
                if (m_axis_tready) begin
                    state_d = IDLE;
                    if (tlast_c) begin
                        beat_d = 16'd0;
                        last_d = 1'b1;
                    end else begin
                        beat_d = beat_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= IDLE;
            div_q     <= 8'd0;
            bit_q     <= 6'd0;
            sck_q     <= 1'b0;
            shift_q   <= '0;
            beat_q    <= 16'd0;
            last_q    <= 1'b0;
            overrun_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sck_q     <= sck_d;
            shift_q   <= shift_d;
            beat_q    <= beat_d;
            last_q    <= last_d;
            overrun_q <= overrun_d;
            armed_q   <= armed_d;
        end
    end

    // armed_q keeps ready low while reset is held, even though state reads IDLE
    assign ready         = (state_q == IDLE) && armed_q;
    assign sck           = sck_q;
    assign m_axis_tvalid = (state_q == OUTPUT);
    assign m_axis_tlast  = m_axis_tvalid && tlast_c;
    assign m_axis_tdata  = 32'(shift_q);
    assign last          = last_q;
    assign overrun       = overrun_q;

endmodule
